// File: rtl/add_serial2b.sv
// Serial W-bit adder: consumes operands two bits per cycle, LSB slice first,
// through one 2-bit ripple slice, with a start/done handshake to the datapath.

module add_serial2b_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_serial2b #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         co
);
    localparam int NS = W / 2;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    generate
        if (W < 2 || (W % 2) != 0) begin : g_bad_width
            $error("add_serial2b: W must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   xs, ys, acc, acc_nx;
    logic           c;
    logic [CW-1:0]  cnt;
    logic           s0, s1, c1, c2;
    logic           accept, last;

    add_serial2b_fa u_fa0 (.a(xs[0]), .b(ys[0]), .ci(c),  .s(s0), .co(c1));
    add_serial2b_fa u_fa1 (.a(xs[1]), .b(ys[1]), .ci(c1), .s(s1), .co(c2));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        last     = (cnt == CW'(NS - 1));
        // Sum register shifts right; the new slice lands in the top two bits.
        acc_nx            = acc >> 2;
        acc_nx[W-1 -: 2]  = {s1, s0};
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            xs  <= '0;
            ys  <= '0;
            acc <= '0;
            c   <= 1'b0;
            cnt <= '0;
            z   <= '0;
            co  <= 1'b0;
        end else if (accept) begin
            xs  <= x;
            ys  <= y;
            acc <= '0;
            c   <= ci;
            cnt <= '0;
        end else if (state == RUN) begin
            xs  <= xs >> 2;
            ys  <= ys >> 2;
            acc <= acc_nx;
            c   <= c2;
            cnt <= cnt + 1'b1;
            if (last) begin
                z  <= acc_nx;
                co <= c2;
            end
        end
    end
endmodule

// File: tb/tb_add_serial2b.sv
// Randomized and directed checks of add_serial2b (W=8 and W=2) against
// plain-arithmetic expectations of {co,z} = x + y + ci.

module tb_add_serial2b;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;

    logic       start8 = 1'b0, ci8 = 1'b0, busy8, done8, co8;
    logic [7:0] x8 = '0, y8 = '0, z8;
    logic       start2 = 1'b0, ci2 = 1'b0, busy2, done2, co2;
    logic [1:0] x2 = '0, y2 = '0, z2;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] prev8 = '0;
    logic [8:0] prev2 = '0;

    add_serial2b #(.W(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .x(x8), .y(y8), .ci(ci8),
        .busy(busy8), .done(done8), .z(z8), .co(co8)
    );

    add_serial2b #(.W(2)) dut2 (
        .clk(clk), .rst_b(rst_b), .start(start2), .x(x2), .y(y2), .ci(ci2),
        .busy(busy2), .done(done2), .z(z2), .co(co2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] result(input bit w2);
        return w2 ? {6'b0, co2, z2} : {co8, z8};
    endfunction

    function automatic logic get_busy(input bit w2);
        return w2 ? busy2 : busy8;
    endfunction

    function automatic logic get_done(input bit w2);
        return w2 ? done2 : done8;
    endfunction

    task automatic drive(input bit w2, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        if (w2) begin
            start2 = st; x2 = a[1:0]; y2 = b[1:0]; ci2 = c;
        end else begin
            start8 = st; x8 = a; y8 = b; ci8 = c;
        end
    endtask

    // Leaves the caller in the DONE cycle, so calling again is back-to-back.
    task automatic run_op(input bit w2, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input bit poke);
        int         n;
        logic [8:0] exp;
        logic [8:0] prev;
        n    = w2 ? 1 : 4;
        prev = w2 ? prev2 : prev8;
        if (w2) exp = 9'(a[1:0]) + 9'(b[1:0]) + 9'(c);
        else    exp = 9'(a) + 9'(b) + 9'(c);
        @(negedge clk) drive(w2, 1'b1, a, b, c);
        @(posedge clk); #1;
        check("busy_e0", 64'(get_busy(w2)), 64'(1));
        check("done_e0", 64'(get_done(w2)), 64'(0));
        check("hold_e0", 64'(result(w2)), 64'(prev));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (poke && k == 2) drive(w2, 1'b1, ~a, 8'($urandom), ~c);
            else                drive(w2, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (k < n) begin
                check("busy_run", 64'(get_busy(w2)), 64'(1));
                check("done_run", 64'(get_done(w2)), 64'(0));
                check("hold_run", 64'(result(w2)), 64'(prev));
            end else begin
                check("busy_done", 64'(get_busy(w2)), 64'(0));
                check("done_pulse", 64'(get_done(w2)), 64'(1));
                check("sum", 64'(result(w2)), 64'(exp));
            end
        end
        if (w2) prev2 = exp;
        else    prev8 = exp;
    endtask

    task automatic idle_check(input bit w2);
        @(negedge clk) drive(w2, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        @(posedge clk); #1;
        check("done_drop", 64'(get_done(w2)), 64'(0));
        check("busy_idle", 64'(get_busy(w2)), 64'(0));
        check("hold_idle", 64'(result(w2)), 64'(w2 ? prev2 : prev8));
    endtask

    initial begin
        #1;
        check("rst_z8", 64'({co8, z8}), 64'(0));
        check("rst_flags8", 64'({busy8, done8}), 64'(0));
        check("rst_z2", 64'({co2, z2}), 64'(0));
        @(negedge clk) rst_b = 1'b1;

        run_op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); idle_check(1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0); idle_check(1'b0);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        run_op(1'b0, 8'h10, 8'h20, 1'b1, 1'b0); idle_check(1'b0);
        run_op(1'b0, 8'h55, 8'hAA, 1'b0, 1'b0); idle_check(1'b0);

        // Abort mid-operation: prev result is 0x0FF, so clearing is visible.
        @(negedge clk) drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        @(negedge clk) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("busy_pre_rst", 64'(busy8), 64'(1));
        @(negedge clk) rst_b = 1'b0;
        #1;
        check("rst_mid_z", 64'({co8, z8}), 64'(0));
        check("rst_mid_flags", 64'({busy8, done8}), 64'(0));
        prev8 = '0;
        prev2 = '0;
        @(negedge clk) rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 64'({busy8, done8}), 64'(0));
        end

        for (int i = 0; i < 24; i++) begin
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) idle_check(1'b0);
        end
        idle_check(1'b0);

        run_op(1'b1, 8'd1, 8'd3, 1'b0, 1'b0); idle_check(1'b1);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(1'b1, 8'(a), 8'(b), 1'(c), 1'b0);
                    if (c == 1) idle_check(1'b1);
                end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_serial2b.md
Name: add_serial2b

Overview:
- Sequential W-bit adder that feeds operands 2 bits per cycle, LSB slice first, into an internal 2-bit ripple-adder slice built from full-adder cells.
- Carry between slices is held in a register.
- Trades latency for area: a single 2-bit slice serves any even operand width W.
- Start/done handshake to the surrounding datapath; the result is held until the next operation completes.

Parameters:
- W, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising-edge active
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request an addition; sampled only when the block can accept (IDLE or DONE)
- x  input  W  operand A; sampled on the accepting edge only
- y  input  W  operand B; sampled on the accepting edge only
- ci  input  1  carry-in; sampled on the accepting edge only
- busy  output  1  high while slices are being processed (RUN)
- done  output  1  one-cycle pulse: z/co were updated on the preceding edge
- z  output  W  sum, registered
- co  output  1  carry-out, registered

Behaviour:
- Reset (rst_b low, asynchronous): state=IDLE, busy=0, done=0, z=0, co=0. Internal operand shift registers, carry register and slice counter are cleared. Reset is effective immediately, including mid-operation; any in-flight operation is discarded and no done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch x, y into shift registers, carry reg=ci, counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - Compute s = xs[1:0] + ys[1:0] + c (3-bit result).
  - Shift xs, ys right by 2.
  - Shift s[1:0] into the top 2 bits of the internal sum register (sum register shifts right by 2).
  - c = s[2]; counter += 1.
  - On the edge processing slice W/2-1: copy the sum (including this slice) to z, copy the final carry to co, go to DONE.
- DONE (done=1, busy=0), next edge:
  - start=1: accept a new operation exactly as from IDLE (back-to-back, no idle cycle).
  - start=0: go to IDLE.
- Latency:
  - Accepting edge = E0. Slices are processed on edges E1..E(W/2).
  - z/co are valid and done=1 in the cycle after edge E(W/2).
  - W=8: done is high in cycle 5 after the start edge.
  - Throughput: one addition per W/2+1 cycles.
- z/co hold the previous result throughout RUN and change only on entry to DONE.
- start while in RUN: ignored; no effect on operands, counter or outputs.
- x/y/ci changes outside the accepting edge: no effect.
- Arithmetic: {co,z} = x + y + ci, exact modulo 2^(W+1); no overflow flag.
- W=2: a single RUN cycle.
- Counter width: clog2(W/2), minimum 1 bit.

Test Plan:
- Reset then W=8, x=0x00, y=0x00, ci=0, start pulse -> busy=1 for 4 cycles; done=1 for exactly 1 cycle, 5 cycles after start; z=0x00, co=0.
- Carry propagation:
  - x=0xFF, y=0x01, ci=0 -> z=0x00, co=1.
  - x=0xFF, y=0xFF, ci=1 -> z=0xFF, co=1.
  - x=0x55, y=0xAA, ci=0 -> z=0xFF, co=0.
- Hold and ignore:
  - Pulse start again during RUN with different x/y -> ignored; result matches the first operands.
  - z/co keep the old value until the done cycle.
- Back-to-back: assert start in the DONE cycle with x=0x10, y=0x20, ci=1 -> no IDLE cycle; second done 5 cycles later; z=0x31, co=0.
- Reset mid-operation: drop rst_b during RUN slice 2 -> outputs 0 immediately; no done pulse; a new start after release gives a correct result.
- W=2 instance: x=1, y=3, ci=0 -> done 2 cycles after start, z=0, co=1.
- Exhaustive W=2: all x, y, ci -> {co,z} == x+y+ci.
